// File: rtl/ram_read_streamer_if.sv
// Address-in / data-out stream pair of the RAM read streamer.
// slave is the streamer's view, master is the producer/consumer side.
interface ram_read_streamer_if #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  addr_valid;
  logic                  addr_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  data_valid;
  logic                  data_ready;
  logic [WORD_WIDTH-1:0] data;

  modport slave (
    input  addr_valid, addr, data_ready,
    output addr_ready, data_valid, data
  );

  modport master (
    output addr_valid, addr, data_ready,
    input  addr_ready, data_valid, data
  );
endinterface

// File: rtl/ram_read_streamer.sv
// Turns the fixed 1-cycle read of a simple dual-port RAM into valid/ready
// address and data streams, using a 2-entry output buffer with credit accounting.
module ram_read_streamer #(
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  ram_read_streamer_if.slave    stream,
  output logic                  ram_rden,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [WORD_WIDTH-1:0] ram_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_ONE,
    FILL_TWO
  } fill_t;

  fill_t                 fill_q, fill_d;
  logic                  inflight_q;
  logic [WORD_WIDTH-1:0] buf_q [2];
  logic [WORD_WIDTH-1:0] buf_d [2];

  logic full;
  logic pop;
  logic accept;
  logic capture;

  // Credits: a read in flight reserves a buffer slot until its word lands.
  assign full    = (fill_q == FILL_TWO) || ((fill_q == FILL_ONE) && inflight_q);
  assign pop     = stream.data_valid & stream.data_ready;
  assign capture = inflight_q;

  assign stream.addr_ready = ~clear & (~full | pop);
  assign accept            = stream.addr_valid & stream.addr_ready;
  assign ram_rden          = accept;
  assign ram_read_addr     = stream.addr;

  assign stream.data_valid = (fill_q != FILL_EMPTY);
  assign stream.data       = buf_q[0];
  assign busy              = (fill_q != FILL_EMPTY) | inflight_q;

  always_comb begin
    fill_d    = fill_q;
    buf_d[0]  = buf_q[0];
    buf_d[1]  = buf_q[1];
    case ({capture, pop})
      2'b10: begin
        case (fill_q)
          FILL_EMPTY: begin
            buf_d[0] = ram_read_data;
            fill_d   = FILL_ONE;
          end
          FILL_ONE: begin
            buf_d[1] = ram_read_data;
            fill_d   = FILL_TWO;
          end
          default: ;
        endcase
      end
      2'b01: begin
        buf_d[0] = buf_q[1];
        fill_d   = (fill_q == FILL_TWO) ? FILL_ONE : FILL_EMPTY;
      end
      2'b11: begin
        // Head leaves while the new word joins behind whatever remains.
        if (fill_q == FILL_TWO) begin
          buf_d[0] = buf_q[1];
          buf_d[1] = ram_read_data;
        end else begin
          buf_d[0] = ram_read_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      fill_q     <= FILL_EMPTY;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      fill_q     <= fill_d;
      inflight_q <= accept;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
    end
  end

endmodule
